// File: rtl/seq_stim_gen_6_5_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_stim_gen_6_5_if
// Description : Control/stimulus bundle between the sequence stimulus
//               generator and its host (switches/buttons or testbench).
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_stim_gen_6_5_if;
    logic       start;
    logic [1:0] mode;
    logic       z_in;
    logic       x2;
    logic       x1;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_step;
    logic [2:0] step;

    modport master (
        output start, mode, z_in,
        input  x2, x1, busy, done, pass, err_step, step
    );

    modport slave (
        input  start, mode, z_in,
        output x2, x1, busy, done, pass, err_step, step
    );
endinterface
`default_nettype wire

// File: rtl/seq_stim_gen_6_5.sv
`default_nettype none
// ============================================================================
// Module      : seq_stim_gen_6_5
// Description : Drives (x2,x1) of the async 00->10->11 detector with one of
//               four single-bit-step patterns and checks its z output.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_stim_gen_6_5 #(
    parameter int DWELL = 50000000,
    parameter int CNT_W = 27
) (
    input  logic                sys_clk_in,
    input  logic                sys_rst_n,
    seq_stim_gen_6_5_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_LAST   = CNT_W'(DWELL - 1);
    localparam logic [2:0]       c_NO_ERR = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_step;
    logic [1:0]       r_x;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [2:0]       r_err;
    logic [1:0]       r_sync;

    // Code table as x2x1; unlisted indices are 00.
    function automatic logic [1:0] f_code(input logic [1:0] m, input logic [2:0] idx);
        logic [1:0] v;
        v = 2'b00;
        case ({m, idx})
            5'b00_001: v = 2'b10;
            5'b00_010: v = 2'b11;
            5'b01_001: v = 2'b01;
            5'b01_010: v = 2'b11;
            5'b10_001: v = 2'b10;
            5'b10_011: v = 2'b10;
            5'b10_100: v = 2'b11;
            5'b11_001: v = 2'b10;
            5'b11_010: v = 2'b11;
            5'b11_011: v = 2'b01;
            default:   v = 2'b00;
        endcase
        return v;
    endfunction

    function automatic logic f_exp(input logic [1:0] m, input logic [2:0] idx);
        return ({m, idx} == 5'b00_010) || ({m, idx} == 5'b10_100) ||
               ({m, idx} == 5'b11_010);
    endfunction

    logic       w_z_s;
    logic       w_last_cnt;
    logic [2:0] w_len_m1;
    logic [2:0] w_next_step;
    logic       w_mismatch;
    logic [1:0] w_first_code;

    assign w_z_s        = r_sync[1];
    assign w_last_cnt   = (r_cnt == c_LAST);
    assign w_len_m1     = r_mode[1] ? 3'd4 : 3'd2;
    assign w_next_step  = r_step + 3'd1;
    assign w_mismatch   = (w_z_s != f_exp(r_mode, r_step));
    assign w_first_code = f_code(bus.mode, 3'd0);

    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= 2'd0;
            r_cnt   <= '0;
            r_step  <= 3'd0;
            r_x     <= 2'b00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= c_NO_ERR;
            r_sync  <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], bus.z_in};
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_mode <= bus.mode;
                        r_busy <= 1'b1;
                        r_done <= 1'b0;
                        r_pass <= 1'b0;
                        r_err  <= c_NO_ERR;
                        r_cnt  <= '0;
                        r_step <= 3'd0;
                        // Leaving 11 directly for 00 would flip both bits, so detour via 01.
                        if (r_x == 2'b11) begin
                            r_state <= S_PREP;
                            r_x     <= 2'b01;
                        end else begin
                            r_state <= S_RUN;
                            r_x     <= w_first_code;
                        end
                    end
                end
                S_PREP: begin
                    if (w_last_cnt) begin
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                        r_x     <= f_code(r_mode, 3'd0);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (w_last_cnt) begin
                        if (w_mismatch && (r_err == c_NO_ERR))
                            r_err <= r_step;
                        if (r_step == w_len_m1) begin
                            r_state <= S_FIN;
                        end else begin
                            r_step <= w_next_step;
                            r_cnt  <= '0;
                            r_x    <= f_code(r_mode, w_next_step);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (r_err == c_NO_ERR);
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.x2       = r_x[1];
    assign bus.x1       = r_x[0];
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.pass     = r_pass;
    assign bus.err_step = r_err;
    assign bus.step     = r_step;

endmodule
`default_nettype wire

// File: tb/tb_seq_stim_gen_6_5.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_stim_gen_6_5
// Description : Self-checking bench with a behavioural detector and a
//               pattern-table reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_stim_gen_6_5;

    localparam int c_D = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    seq_stim_gen_6_5_if bus ();

    seq_stim_gen_6_5 #(.DWELL(c_D), .CNT_W(4)) dut (
        .sys_clk_in (clk),
        .sys_rst_n  (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference pattern table: codes (x2x1) and expected z per step
    int         pat_len [4];
    logic [1:0] pat_code[4][5];
    logic       pat_exp [4][5];

    // Behavioural async detector: 1=saw 00, 2=saw 00,10, 3=detected
    int det_s = 1;
    int zsrc  = 0;   // 0 detector, 1 tied 0, 2 tied 1

    function automatic int det_next(input int s, input logic [1:0] xv);
        case (xv)
            2'b00:   return 1;
            2'b10:   return (s == 1 || s == 2) ? 2 : 0;
            2'b11:   return (s == 2 || s == 3) ? 3 : 0;
            default: return 0;
        endcase
    endfunction

    always @(bus.x2 or bus.x1) det_s = det_next(det_s, {bus.x2, bus.x1});

    assign bus.z_in = (zsrc == 0) ? (det_s == 3) : (zsrc == 2);

    // Cycle monitor: single-bit x changes and busy/done exclusivity
    int         mon_bad = 0;
    bit         mon_valid = 0;
    logic [1:0] mon_prev;
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            mon_valid = 0;
        end else begin
            if (mon_valid && (({bus.x2, bus.x1} ^ mon_prev) == 2'b11)) mon_bad++;
            if (bus.busy === 1'b1 && bus.done === 1'b1) mon_bad++;
            mon_prev  = {bus.x2, bus.x1};
            mon_valid = 1;
        end
    end

    task automatic run_and_check(input string name, input int m, input int zs, input int inject_at);
        logic [1:0] exp_x[$];
        logic [2:0] exp_st[$];
        logic [1:0] got_x[$];
        logic [2:0] got_st[$];
        int  s, err, cyc, bad0, first_bad;
        bit  prep, zv;
        @(negedge clk);
        zsrc = zs;
        prep = ({bus.x2, bus.x1} == 2'b11);
        if (prep) repeat (c_D) begin exp_x.push_back(2'b01); exp_st.push_back(3'd0); end
        for (int i = 0; i < pat_len[m]; i++)
            repeat (c_D) begin exp_x.push_back(pat_code[m][i]); exp_st.push_back(3'(i)); end
        exp_x.push_back(pat_code[m][pat_len[m]-1]);
        exp_st.push_back(3'(pat_len[m]-1));
        s = det_s;
        if (prep) s = det_next(s, 2'b01);
        err = 7;
        for (int i = 0; i < pat_len[m]; i++) begin
            s  = det_next(s, pat_code[m][i]);
            zv = (zs == 0) ? (s == 3) : (zs == 2);
            if (zv != pat_exp[m][i] && err == 7) err = i;
        end
        bad0 = mon_bad;
        bus.start = 1'b1;
        bus.mode  = 2'(m);
        @(negedge clk);
        bus.start = 1'b0;
        bus.mode  = 2'($urandom);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 200) begin
            got_x.push_back({bus.x2, bus.x1});
            got_st.push_back(bus.step);
            cyc++;
            bus.start = (cyc == inject_at);
            if (cyc == inject_at) bus.mode = 2'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;

        checks++;
        if (cyc !== exp_x.size()) begin
            failures++;
            $display("FAIL %s run_length: got %0d cycles, expected %0d", name, cyc, exp_x.size());
        end
        first_bad = -1;
        for (int i = 0; i < got_x.size() && i < exp_x.size(); i++)
            if (first_bad < 0 && (got_x[i] !== exp_x[i] || got_st[i] !== exp_st[i])) first_bad = i;
        checks++;
        if (first_bad >= 0) begin
            failures++;
            $display("FAIL %s trace: cycle %0d got x=%b step=%0d, expected x=%b step=%0d", name,
                     first_bad, got_x[first_bad], got_st[first_bad], exp_x[first_bad], exp_st[first_bad]);
        end
        checks++;
        if (bus.pass !== (err == 7)) begin
            failures++;
            $display("FAIL %s pass: got %b, expected %b", name, bus.pass, (err == 7));
        end
        checks++;
        if (bus.err_step !== 3'(err)) begin
            failures++;
            $display("FAIL %s err_step: got %0d, expected %0d", name, bus.err_step, err);
        end
        checks++;
        if ({bus.x2, bus.x1} !== pat_code[m][pat_len[m]-1] || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s final_state: got x=%b busy=%b, expected x=%b busy=0", name,
                     {bus.x2, bus.x1}, bus.busy, pat_code[m][pat_len[m]-1]);
        end
        checks++;
        if (mon_bad !== bad0) begin
            failures++;
            $display("FAIL %s monitor: got %0d violations, expected 0", name, mon_bad - bad0);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.x2, bus.x1, bus.busy, bus.done, bus.pass} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got x=%b busy=%b done=%b pass=%b, expected all 0",
                     {bus.x2, bus.x1}, bus.busy, bus.done, bus.pass);
        end
        checks++;
        if (bus.err_step !== 3'd7 || bus.step !== 3'd0) begin
            failures++;
            $display("FAIL reset_idx: got err_step=%0d step=%0d, expected 7 and 0", bus.err_step, bus.step);
        end
    endtask

    task automatic test_mode0();        run_and_check("mode0_detector", 0, 0, -1); endtask
    task automatic test_prep_mode1();   run_and_check("mode1_prep", 1, 0, -1);     endtask
    task automatic test_mode2_tie0();   run_and_check("mode2_tie0", 2, 1, -1);     endtask
    task automatic test_mode3();        run_and_check("mode3_detector", 3, 0, -1); endtask

    task automatic test_start_ignored();
        int p;
        p = ({bus.x2, bus.x1} == 2'b11) ? 1 : 0;
        run_and_check("start_while_busy", 0, 0, p * c_D + c_D + 4);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_and_check($sformatf("random_%0d", r), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)), -1);
        end
    endtask

    task automatic test_reset_midrun();
        int w;
        @(negedge clk);
        zsrc = 0;
        bus.start = 1'b1;
        bus.mode  = 2'd0;
        @(negedge clk);
        bus.start = 1'b0;
        w = 0;
        while (bus.step !== 3'd2 && w < 100) begin @(negedge clk); w++; end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.step !== 3'd2 || {bus.x2, bus.x1} !== 2'b11 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL midrun_pre: got step=%0d x=%b busy=%b, expected 2 11 1",
                     bus.step, {bus.x2, bus.x1}, bus.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.x2, bus.x1} !== 2'b00 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.err_step !== 3'd7) begin
            failures++;
            $display("FAIL async_reset: got x=%b busy=%b done=%b err=%0d, expected 00 0 0 7",
                     {bus.x2, bus.x1}, bus.busy, bus.done, bus.err_step);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.mode  = 2'd0;
        pat_len = '{3, 3, 5, 5};
        for (int m = 0; m < 4; m++)
            for (int i = 0; i < 5; i++) begin
                pat_code[m][i] = 2'b00;
                pat_exp[m][i]  = 1'b0;
            end
        pat_code[0][1] = 2'b10; pat_code[0][2] = 2'b11; pat_exp[0][2] = 1'b1;
        pat_code[1][1] = 2'b01; pat_code[1][2] = 2'b11;
        pat_code[2][1] = 2'b10; pat_code[2][3] = 2'b10; pat_code[2][4] = 2'b11; pat_exp[2][4] = 1'b1;
        pat_code[3][1] = 2'b10; pat_code[3][2] = 2'b11; pat_code[3][3] = 2'b01; pat_exp[3][2] = 1'b1;

        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_mode0();
        test_prep_mode1();
        test_mode2_tie0();
        test_mode3();
        test_start_ignored();
        test_random();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_stim_gen_6_5.md
Name: seq_stim_gen_6_5

Overview:
- Clocked transmitter that drives the (x2, x1) input pair of the asynchronous 00->10->11 sequence detector.
- Emits one of four fixed, fundamental-mode-safe input patterns, holding each code for a programmable dwell.
- Samples the detector's z output at the end of each step and reports pass/fail with the first failing step index.
- Sits on the EGO1 top level between the switch/button inputs and the detector instance, and replaces hand-toggled switches as the detector's stimulus.

Parameters:
- DWELL, 50000000: clock cycles each code is held; legal range 4 to 2^27-1.
- CNT_W, 27: dwell counter width; must hold DWELL-1.

Ports:
- sys_clk_in  input  1  board clock (100 MHz).
- sys_rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to run a pattern; ignored while busy=1.
- mode  input  2  pattern select, latched in the cycle start is accepted.
- z_in  input  1  detector output; asynchronous to sys_clk_in.
- x2  output  1  detector input x2, registered.
- x1  output  1  detector input x1, registered.
- busy  output  1  high from the cycle after start is accepted until done rises.
- done  output  1  level; high after a run until the next accepted start.
- pass  output  1  valid while done=1; 1 when every step matched.
- err_step  output  3  first mismatching step index; 7 means none. Valid while done=1.
- step  output  3  index of the code currently driven; 0 when idle.

Behaviour:
- Reset (async, sys_rst_n=0): x2=x1=0, busy=0, done=0, pass=0, err_step=7, step=0, FSM=IDLE, synchronizer flops=0.
- z_in passes through a 2-flop synchronizer; only the synchronized value z_s is used.
- Patterns (codes as x2x1, expected z_s in brackets):
  - mode 0, 3 steps: 00[0] 10[0] 11[1]
  - mode 1, 3 steps: 00[0] 01[0] 11[0]
  - mode 2, 5 steps: 00[0] 10[0] 00[0] 10[0] 11[1]
  - mode 3, 5 steps: 00[0] 10[0] 11[1] 01[0] 00[0]
  - Every consecutive pair of codes differs in exactly one bit. The generator never changes x2 and x1 in the same cycle.
- FSM states:
  - IDLE: waits for start.
  - PREP: runs only if the held code is 11 when start is accepted. Drives 01 for DWELL cycles; z is not checked. Then goes to RUN.
  - RUN: drives code[step] for DWELL cycles.
  - FIN: single cycle; sets done and pass, clears busy.
  - DONE: holds the last code; waits for start.
- Accept start:
  - start=1 in IDLE or DONE is accepted.
  - At the next edge: mode is latched, busy=1, done=0, err_step=7.
  - State goes to PREP if the current x is 11, otherwise to RUN with step=0 and x=code[0].
- Start arriving early: start=1 while busy=1 is dropped silently. It is not queued.
- Dwell: the counter counts from 0 to DWELL-1. The new code appears on x in the same edge that loads count=0.
- Check: in the cycle where count=DWELL-1, z_s is compared with expected[step].
  - On a mismatch with err_step=7, err_step takes the value of step.
  - Later mismatches leave err_step unchanged.
- Step advance:
  - If step is less than len-1: step increments, count resets, and the next code is driven.
  - If step equals len-1: go to FIN.
  - In FIN: pass = (err_step==7 and no mismatch on the final check). The final check's result is folded in the same cycle.
- Output after a run: x holds the last code in DONE. x never returns to 00 on its own.
- Latency: accepted start to first x change is 1 cycle, or DWELL+1 cycles when PREP runs. Total run is len*DWELL + 1 cycles, plus DWELL for PREP.
- Reset mid-run: async return to reset values. x drops to 00 immediately, even from 11; this is the only permitted two-bit change.
- Outputs during a run: mode changes after acceptance have no effect. step stays 0 in IDLE and PREP.

Test Plan:
- DWELL=8, reset, then start with mode=0, and z_in modelled by a behavioural detector: x sequence is 00, 10, 11, each code held for 8 cycles. done rises 25 cycles after start; pass=1, err_step=7; x held at 11.
- Immediately rerun mode=1 from x=11: PREP drives 01 for 8 cycles before step 0 with 00. No cycle shows both bits changing. pass=1, err_step=7.
- mode=2 with z_in tied to 0: err_step=4, pass=0. Checker confirms the 00-10-00-10-11 order and 5x8 dwell.
- mode=3 with the detector model: z_s is 1 only at the end of step 2. pass=1; final x=00.
- Pulse start at cycle 3 of step 1 during a run: it is ignored and the run completes unchanged. Then assert sys_rst_n=0 mid-step 2 of a new run: x=00, busy=0, done=0, err_step=7 asynchronously, with no clock edge required.
- Assertion over all runs: popcount(x changes per cycle) ≤ 1 except at reset; busy and done are never both 1.
